// File: rtl/joy_dir_filter.sv
// Multi-channel joystick direction conditioner: sync, rotate, debounce, SOCD clean,
// then 8-way passthrough or 4-way last-pressed / first-pressed selection per channel.
module joy_dir_filter #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned DB_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic [1:0]              mode,
    input  logic [1:0]              rotate,
    input  logic [4*CHANNELS-1:0]   dir_in,
    output logic [4*CHANNELS-1:0]   dir_out,
    output logic [CHANNELS-1:0]     changed
);

    localparam int unsigned DW = 4 * CHANNELS;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'((DB_CYCLES > 0) ? DB_CYCLES - 1 : 0);

    logic [DW-1:0]            s1_q, s2_q;
    logic [DW-1:0]            raw_c, c_c;
    logic [DW-1:0]            db_q, db_d;
    logic [DW-1:0][DB_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]            prev_q;
    logic [DW-1:0]            mask_q, mask_d;
    logic [DW-1:0]            out_d;
    logic [CHANNELS-1:0]      chg_d;
    logic [1:0]               mode_q;
    logic                     mode_chg_c;
    logic [3:0]               cur_c, held_c, rise_c, sel_c;

    // Bit order within a nibble is {up, down, left, right}
    function automatic logic [3:0] rot_dir(input logic [3:0] v, input logic [1:0] r);
        case (r)
            2'd1:    rot_dir = {v[1], v[0], v[2], v[3]};
            2'd2:    rot_dir = {v[2], v[3], v[0], v[1]};
            2'd3:    rot_dir = {v[0], v[1], v[3], v[2]};
            default: rot_dir = v;
        endcase
    endfunction

    function automatic logic [3:0] socd(input logic [3:0] v);
        socd = {v[3] & ~v[2], v[2] & ~v[3], v[1] & ~v[0], v[0] & ~v[1]};
    endfunction

    function automatic logic [3:0] first_set(input logic [3:0] v);
        if (v[3])      first_set = 4'b1000;
        else if (v[2]) first_set = 4'b0100;
        else if (v[1]) first_set = 4'b0010;
        else if (v[0]) first_set = 4'b0001;
        else           first_set = 4'b0000;
    endfunction

    always_comb begin
        raw_c = '0;
        c_c   = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            raw_c[4*ch +: 4] = rot_dir(s2_q[4*ch +: 4], rotate);
            c_c[4*ch +: 4]   = socd(db_q[4*ch +: 4]);
        end
    end

    // Per-bit debounce: follow raw only after DB_CYCLES consecutive ce ticks of disagreement
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int unsigned b = 0; b < DW; b++) begin
            if (DB_CYCLES == 0) begin
                db_d[b]  = raw_c[b];
                cnt_d[b] = '0;
            end else if (raw_c[b] == db_q[b]) begin
                cnt_d[b] = '0;
            end else if (ce) begin
                if (cnt_q[b] == DB_LAST) begin
                    db_d[b]  = raw_c[b];
                    cnt_d[b] = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    assign mode_chg_c = (mode != mode_q);

    // A mode change wipes the mask and ignores edges for that cycle
    always_comb begin
        mask_d = '0;
        out_d  = '0;
        chg_d  = '0;
        cur_c  = '0;
        held_c = '0;
        rise_c = '0;
        sel_c  = '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            cur_c  = c_c[4*ch +: 4];
            held_c = mode_chg_c ? 4'b0000 : mask_q[4*ch +: 4];
            rise_c = mode_chg_c ? 4'b0000 : (cur_c & ~prev_q[4*ch +: 4]);
            sel_c  = held_c;
            case (mode)
                2'd0: sel_c = 4'b0000;
                2'd2: begin
                    if ((cur_c & held_c) == 4'b0000) sel_c = first_set(cur_c);
                end
                default: begin
                    if (rise_c != 4'b0000)
                        sel_c = first_set(rise_c);
                    else if ((cur_c & held_c) == 4'b0000 && cur_c != 4'b0000)
                        sel_c = first_set(cur_c);
                end
            endcase
            mask_d[4*ch +: 4] = sel_c;
            out_d[4*ch +: 4]  = (mode == 2'd0) ? cur_c : (cur_c & sel_c);
            chg_d[ch]         = (out_d[4*ch +: 4] != dir_out[4*ch +: 4]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
            prev_q  <= '0;
            mask_q  <= '0;
            mode_q  <= '0;
            dir_out <= '0;
            changed <= '0;
        end else begin
            s1_q    <= dir_in;
            s2_q    <= s1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            prev_q  <= c_c;
            mask_q  <= mask_d;
            mode_q  <= mode;
            dir_out <= out_d;
            changed <= chg_d;
        end
    end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Scoreboard bench for joy_dir_filter: two instances (no debounce, 4-tick debounce)
// share one stimulus stream and are checked against a compass-level reference model.
module tb_joy_dir_filter;

    localparam int unsigned CH = 2;
    localparam int unsigned DW = 4 * CH;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CH-1:0] c;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ce;
    logic [1:0]    mode, rotate;
    logic [DW-1:0] dir_in;
    logic [DW-1:0] dout0, dout4;
    logic [CH-1:0] chg0, chg4;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;
    logic ce_rand = 1'b0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    joy_dir_filter #(.CHANNELS(CH), .DB_CYCLES(0), .DB_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .ce(ce), .mode(mode), .rotate(rotate),
        .dir_in(dir_in), .dir_out(dout0), .changed(chg0)
    );

    joy_dir_filter #(.CHANNELS(CH), .DB_CYCLES(4), .DB_W(8)) u_dut4 (
        .clk(clk), .reset(reset), .ce(ce), .mode(mode), .rotate(rotate),
        .dir_in(dir_in), .dir_out(dout4), .changed(chg4)
    );

    // Rotation as stepping around the compass U -> R -> D -> L clockwise
    function automatic logic [3:0] m_rot(input logic [3:0] v, input logic [1:0] r);
        int cw [4];
        logic [3:0] o;
        cw = '{3, 0, 2, 1};
        o = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (v[cw[i]]) o[cw[(i + int'(r)) % 4]] = 1'b1;
        return o;
    endfunction

    function automatic logic [3:0] m_pick(input logic [3:0] v);
        for (int b = 3; b >= 0; b--)
            if (v[b]) return 4'(1 << b);
        return 4'b0000;
    endfunction

    function automatic logic [3:0] m_socd(input logic [3:0] v);
        logic [3:0] o;
        o = v;
        if (v[3] && v[2]) o[3:2] = 2'b00;
        if (v[1] && v[0]) o[1:0] = 2'b00;
        return o;
    endfunction

    logic [DW-1:0] m_s1 [2], m_s2 [2], m_db [2], m_prev [2], m_mask [2], m_out [2];
    int            m_cnt [2][DW];
    logic [1:0]    m_mode [2];

    // Reference model: one step per clock, expected outputs queued for the monitor
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin : step
            exp_t          e;
            logic [DW-1:0] raw, c, nout, nmask;
            logic [3:0]    cc, held, fresh, sel;
            int            n;
            e = '0;
            if (reset) begin
                m_s1[k] = '0; m_s2[k] = '0; m_db[k] = '0;
                m_prev[k] = '0; m_mask[k] = '0; m_out[k] = '0;
                m_mode[k] = 2'd0;
                for (int b = 0; b < int'(DW); b++) m_cnt[k][b] = 0;
            end else begin
                n = (k == 0) ? 0 : 4;
                raw = '0; c = '0; nout = '0; nmask = '0;
                for (int ch = 0; ch < int'(CH); ch++) begin
                    raw[4*ch +: 4] = m_rot(m_s2[k][4*ch +: 4], rotate);
                    c[4*ch +: 4]   = m_socd(m_db[k][4*ch +: 4]);
                end
                for (int ch = 0; ch < int'(CH); ch++) begin
                    cc    = c[4*ch +: 4];
                    held  = (mode != m_mode[k]) ? 4'b0000 : m_mask[k][4*ch +: 4];
                    fresh = (mode != m_mode[k]) ? 4'b0000 : (cc & ~m_prev[k][4*ch +: 4]);
                    if (mode == 2'd0)
                        sel = 4'b0000;
                    else if (mode == 2'd2)
                        sel = ((cc & held) != 0) ? held : m_pick(cc);
                    else if (fresh != 0)
                        sel = m_pick(fresh);
                    else if ((cc & held) == 0 && cc != 0)
                        sel = m_pick(cc);
                    else
                        sel = held;
                    nmask[4*ch +: 4] = sel;
                    nout[4*ch +: 4]  = (mode == 2'd0) ? cc : (cc & sel);
                    e.c[ch] = (nout[4*ch +: 4] != m_out[k][4*ch +: 4]);
                end
                for (int b = 0; b < int'(DW); b++) begin
                    if (n == 0) begin
                        m_db[k][b] = raw[b];
                    end else if (raw[b] == m_db[k][b]) begin
                        m_cnt[k][b] = 0;
                    end else if (ce) begin
                        m_cnt[k][b]++;
                        if (m_cnt[k][b] == n) begin
                            m_db[k][b]  = raw[b];
                            m_cnt[k][b] = 0;
                        end
                    end
                end
                m_prev[k] = c;
                m_mask[k] = nmask;
                m_out[k]  = nout;
                m_s2[k]   = m_s1[k];
                m_s1[k]   = dir_in;
                m_mode[k] = mode;
                e.d = nout;
            end
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented output word, plus the asynchronous reset drop
    initial begin : monitor
        logic rst_prev;
        exp_t e;
        rst_prev = 1'b0;
        forever begin
            @(negedge clk or posedge reset);
            if (reset && !rst_prev) begin
                rst_prev = 1'b1;
                #1;
                check("rst_dir_out_db0", 32'(dout0), 32'd0);
                check("rst_changed_db0", 32'(chg0), 32'd0);
                check("rst_dir_out_db4", 32'(dout4), 32'd0);
                check("rst_changed_db4", 32'(chg4), 32'd0);
            end else begin
                if (!reset) rst_prev = 1'b0;
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    check("dir_out_db0", 32'(dout0), 32'(e.d));
                    check("changed_db0", 32'(chg0), 32'(e.c));
                end
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    check("dir_out_db4", 32'(dout4), 32'(e.d));
                    check("changed_db4", 32'(chg4), 32'(e.c));
                end
            end
        end
    end

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'(cyc % 4 == 0);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin : stim
        ce = 1'b0; mode = 2'd1; rotate = 2'd0; dir_in = '0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        // last-pressed: up, then add right
        tick(2);
        dir_in = 8'h08; tick(20);
        dir_in = 8'h09; tick(20);
        // fallback to held direction, then release all
        dir_in = 8'h00; tick(20);
        dir_in = 8'h08; tick(20);
        dir_in = 8'h0A; tick(20);
        dir_in = 8'h08; tick(20);
        dir_in = 8'h00; tick(20);
        // first-pressed hold
        mode = 2'd2; tick(2);
        dir_in = 8'h02; tick(20);
        dir_in = 8'h0A; tick(20);
        dir_in = 8'h08; tick(20);
        dir_in = 8'h00; tick(20);
        dir_in = 8'h05; tick(20);
        dir_in = 8'h00; tick(20);
        // SOCD, 8-way, rotation
        mode = 2'd1; dir_in = 8'h0C; tick(20);
        mode = 2'd0; dir_in = 8'h09; tick(20);
        mode = 2'd1; rotate = 2'd1; dir_in = 8'h08; tick(20);
        rotate = 2'd2; tick(20);
        rotate = 2'd3; tick(20);
        rotate = 2'd0; dir_in = 8'h00; tick(40);
        // debounce glitch shorter than four ce ticks, then a stable press
        dir_in = 8'h08; tick(11);
        dir_in = 8'h00; tick(40);
        dir_in = 8'h08; tick(40);
        // reset in the middle of a debounce count
        dir_in = 8'h04; tick(6);
        do_reset();
        tick(40);
        // independent channels
        dir_in = 8'h80; tick(20);
        dir_in = 8'h81; tick(20);
        dir_in = 8'h21; tick(20);
        dir_in = 8'h24; tick(20);
        // randomized traffic
        ce_rand = 1'b1;
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) rotate = 2'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
            dir_in = 8'($urandom) & 8'($urandom);
            tick($urandom_range(1, 12));
        end
        tick(10);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
